ext_mem_responder: RTL
======================

EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h00100000, meaning the byte address mapped to word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, meaning the storage depth in 32-bit words (power of two).
REQ-003 SHALL have parameter WAIT_STATES, default 2, meaning the wait cycles inserted before ready (0..15).
REQ-004 SHALL have port clk  input  1  meaning the single system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-006 SHALL have port ext_addr  input  32  meaning the byte address from the initiator.
REQ-007 SHALL have port ext_wdata  input  32  meaning the write data (initiator-driven half of the ext_data bus).
REQ-008 SHALL have port ext_rdata  output  32  meaning the read data.
REQ-009 SHALL have port ext_rdata_oe  output  1  meaning that the top level drives ext_rdata onto the shared ext_data bus.
REQ-010 SHALL have port ext_mem_read  input  1  meaning a read request.
REQ-011 SHALL have port ext_mem_write  input  1  meaning a write request.
REQ-012 SHALL have port ext_mem_enable  input  1  meaning chip select.
REQ-013 SHALL have port ext_mem_ready  output  1  meaning the transfer-complete strobe.
REQ-014 SHALL have port ext_mem_err  output  1  meaning an out-of-range access (EXT_MEM_BOUNDS_EN only; tied 0 otherwise).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE, RECOVER.
REQ-016 In IDLE, SHALL latch the address, write data and direction, and go to WAIT (or to DONE if WAIT_STATES=0), when ext_mem_enable && (read||write) at a clk edge.
REQ-017 SHALL let write win and proceed as a write when read and write are both asserted.
REQ-018 SHALL load the WAIT counter with WAIT_STATES-1, decrement it each cycle, and go to DONE on 0.
REQ-019 SHALL assert ext_mem_ready for exactly one cycle in DONE; ready SHALL occur WAIT_STATES+1 cycles after the sampling edge.
REQ-020 SHALL commit a write to storage at the DONE→RECOVER edge, and never earlier.
REQ-021 SHALL hold read data on ext_rdata, with ext_rdata_oe=1, from DONE until the request deasserts.
REQ-022 SHALL compute the word index as (ext_addr-ADDR_BASE)>>2; addr[1:0] SHALL be ignored.
REQ-023 If the request deasserts in WAIT, SHALL abort to IDLE with no commit and no ready.
REQ-024 SHALL remain in RECOVER until read and write are both low, then return to IDLE; a request held high SHALL never be serviced twice.

Reset
REQ-025 On rst_n low, SHALL asynchronously force the FSM to IDLE, ext_mem_ready=0, ext_mem_err=0, ext_rdata=0, ext_rdata_oe=0, and the counter to 0.
REQ-026 SHALL preserve storage contents through reset; a reset during WAIT or DONE SHALL drop the pending write.

Configuration
REQ-027 SHALL treat EXT_MEM_BOUNDS_EN as the macro that compiles in bounds checking.
REQ-028 With EXT_MEM_BOUNDS_EN defined, an index >= DEPTH_WORDS or an address < ADDR_BASE SHALL still complete with ready, SHALL suppress the write, SHALL return 32'hDEADBEEF, and SHALL pulse ext_mem_err together with ready.
REQ-029 Without EXT_MEM_BOUNDS_EN, the index SHALL wrap modulo DEPTH_WORDS and ext_mem_err SHALL be constant 0.

Structure
REQ-030 SHALL place the FSM state enum, the 32'hDEADBEEF error constant and the default ADDR_BASE in shared package mem_bus_pkg.
REQ-031 SHALL contain one sub-module, ext_mem_wait_ctr (loadable down-counter with zero flag).

Verification
REQ-032 Write 0x12345678 to 0x00100010, WAIT_STATES=2 -> ready on the 3rd cycle after sampling; a later read of 0x00100010 returns 0x12345678.
REQ-033 WAIT_STATES=0, read 0x00100000 after reset -> ready 1 cycle after sampling, data 0x00000000, oe=1 until read drops.
REQ-034 Write held high across 5 cycles after ready, data 0xA5A5A5A5 -> exactly one ready pulse and one commit.
REQ-035 Write of 0x11111111 to 0x00100020 deasserted during WAIT -> no ready; a read of 0x00100020 returns the prior value.
REQ-036 EXT_MEM_BOUNDS_EN, read 0x00104000 (DEPTH_WORDS=4096) -> ready, data 0xDEADBEEF, err=1 for one cycle; undefined macro -> wraps to word 0.
REQ-037 rst_n pulsed low during WAIT of a write -> ready=0 immediately, FSM in IDLE, storage unchanged.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the external memory responder: FSM state encoding,
// the error read-back word and the default base address.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RECOVER = 2'd3
  } mem_state_e;

  localparam logic [31:0] MEM_ERR_DATA      = 32'hDEADBEEF;
  localparam logic [31:0] MEM_ADDR_BASE_DEF = 32'h00100000;

  // Byte offset from the window base; the word index is taken from bits above [1:0].
  function automatic logic [31:0] mem_byte_offset(input logic [31:0] addr,
                                                  input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/ext_mem_wait_ctr.sv
// Loadable 4-bit down-counter with a zero flag; load has priority over decrement.
// Decrement saturates at zero so a stray i_dec can never wrap the count.
module ext_mem_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/ext_mem_responder.sv
// Wait-stated 32-bit memory target: ready WAIT_STATES+1 cycles after the request is sampled,
// writes commit on leaving DONE. Define EXT_MEM_BOUNDS_EN to flag out-of-window accesses.
module ext_mem_responder
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = MEM_ADDR_BASE_DEF,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_rdata_oe,
  input  logic        ext_mem_read,
  input  logic        ext_mem_write,
  input  logic        ext_mem_enable,
  output logic        ext_mem_ready,
  output logic        ext_mem_err
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LP_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_is_write;
  logic [31:0] r_rdata;
  logic        r_oe;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_ctr_load;
  logic          w_ctr_dec;
  logic          w_ctr_zero;
  logic          w_enter_done;
  logic          w_cur_write;
  logic          w_commit;
  logic          w_oob;
  logic [31:0]   w_cur_addr;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_unused_bits;

  assign w_req = ext_mem_enable && (ext_mem_read || ext_mem_write);

  // In IDLE nothing is latched yet, so the zero-wait path decodes the live bus.
  assign w_cur_addr  = (r_state == ST_IDLE) ? ext_addr : r_addr;
  assign w_cur_write = (r_state == ST_IDLE) ? ext_mem_write : r_is_write;
  assign w_off       = mem_byte_offset(w_cur_addr, ADDR_BASE);
  assign w_idx       = w_off[AW+1:2];
  assign w_unused_bits = ^{w_off[31:AW+2], w_off[1:0]};

`ifdef EXT_MEM_BOUNDS_EN
  logic r_err;
  assign w_oob = (w_cur_addr < ADDR_BASE) || ({2'b00, w_off[31:2]} >= 32'(DEPTH_WORDS));
  assign ext_mem_err = r_err;
`else
  assign w_oob = 1'b0;
  assign ext_mem_err = 1'b0;
`endif

  ext_mem_wait_ctr u_wait_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_ctr_load),
    .i_load_val (LP_LOAD),
    .i_dec      (w_ctr_dec),
    .o_zero     (w_ctr_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ctr_load  = 1'b0;
    w_ctr_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_ctr_load  = 1'b1;
          w_state_nxt = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_ctr_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_ctr_dec = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_RECOVER;
      ST_RECOVER: begin
        // A request still held high must drop before the next one is accepted.
        if (!ext_mem_read && !ext_mem_write) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
  assign w_commit     = (r_state == ST_DONE) && r_is_write && !w_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
      r_rdata    <= 32'd0;
      r_oe       <= 1'b0;
`ifdef EXT_MEM_BOUNDS_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_req) begin
        r_addr     <= ext_addr;
        r_wdata    <= ext_wdata;
        r_is_write <= ext_mem_write;
      end
      if (w_enter_done) begin
        if (!w_cur_write) begin
          r_rdata <= w_oob ? MEM_ERR_DATA : r_mem[w_idx];
          r_oe    <= 1'b1;
        end else begin
          r_oe    <= 1'b0;
        end
      end else if (!ext_mem_read) begin
        r_oe <= 1'b0;
      end
`ifdef EXT_MEM_BOUNDS_EN
      r_err <= w_enter_done && w_oob;
`endif
    end
  end

  // Storage deliberately has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign ext_mem_ready = (r_state == ST_DONE);
  assign ext_rdata     = r_rdata;
  assign ext_rdata_oe  = r_oe;

endmodule
